// File: rtl/need_bar_pkg.sv
// Shared constants for the need-bar renderer: colour width, named colours and default palette.
package need_bar_pkg;

    localparam int unsigned COLOR_W = 24;

    typedef logic [COLOR_W-1:0] color_t;

    localparam color_t C_GREEN  = 24'h00ff00;
    localparam color_t C_YELLOW = 24'hffff00;
    localparam color_t C_RED    = 24'hff0000;
    localparam color_t C_LIME   = 24'h25ff00;
    localparam color_t C_PURPLE = 24'hb70cf2;
    localparam color_t C_BLACK  = 24'h000000;

    localparam int unsigned DEFAULT_NUM_BARS = 5;

    // Bar 0 sits in the LSBs.
    localparam logic [DEFAULT_NUM_BARS*COLOR_W-1:0] DEFAULT_PALETTE =
        {C_PURPLE, C_LIME, C_RED, C_YELLOW, C_GREEN};

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/need_bar_channel.sv
// One need bar: steps the displayed level toward the requested level once per frame
// and keeps the registered low-level alarm in step with it.
module need_bar_channel
    import need_bar_pkg::*;
#(
    parameter int unsigned LEVEL_W    = 3,
    parameter int unsigned LOW_THRESH = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               frame_start_i,
    input  logic [LEVEL_W-1:0] level_i,
    output logic [LEVEL_W-1:0] disp_level_o,
    output logic               alarm_o
);

    logic [LEVEL_W-1:0] disp_q, disp_d;
    logic               alarm_q, alarm_d;

    // Stepping toward the target can never overshoot, so no wrap is possible.
    always_comb begin
        disp_d = disp_q;
        if (frame_start_i) begin
            if (disp_q < level_i) begin
                disp_d = disp_q + LEVEL_W'(1);
            end else if (disp_q > level_i) begin
                disp_d = disp_q - LEVEL_W'(1);
            end
        end
        alarm_d = (32'(disp_d) <= LOW_THRESH);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            disp_q  <= '0;
            alarm_q <= 1'b1;
        end else begin
            disp_q  <= disp_d;
            alarm_q <= alarm_d;
        end
    end

    assign disp_level_o = disp_q;
    assign alarm_o      = alarm_q;

endmodule

// File: rtl/need_bar_renderer.sv
// Two-stage pixel renderer for the need-status bars: address decode and state sampling,
// then colour selection with low-level blink.
module need_bar_renderer
    import need_bar_pkg::*;
#(
    parameter int unsigned NUM_BARS     = 5,
    parameter int unsigned LEVEL_W      = 3,
    parameter int unsigned PIX_W        = 7,
    parameter int unsigned BAR_BASE     = 64,
    parameter int unsigned BAR_STRIDE   = 8,
    parameter int unsigned LOW_THRESH   = 1,
    parameter int unsigned BLINK_FRAMES = 16,
    parameter logic [NUM_BARS*COLOR_W-1:0] PALETTE = DEFAULT_PALETTE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_start,
    input  logic [NUM_BARS*LEVEL_W-1:0] levels,
    input  logic                        pixel_valid,
    input  logic [PIX_W-1:0]            pixel_addr,
    output logic                        color_valid,
    output logic [COLOR_W-1:0]          color_out,
    output logic [NUM_BARS-1:0]         alarm
);

    localparam int unsigned SEGS  = 2 ** LEVEL_W;
    localparam int unsigned BAR_W = clog2_min1(NUM_BARS);
    localparam int unsigned CNT_W = clog2_min1(BLINK_FRAMES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [LEVEL_W-1:0] disp_level [NUM_BARS];
    logic [NUM_BARS-1:0] alarm_vec;

    for (genvar i = 0; i < NUM_BARS; i++) begin : g_bar
        need_bar_channel #(
            .LEVEL_W   (LEVEL_W),
            .LOW_THRESH(LOW_THRESH)
        ) u_channel (
            .clk_i        (clk),
            .rst_i        (rst),
            .frame_start_i(frame_start),
            .level_i      (levels[i*LEVEL_W +: LEVEL_W]),
            .disp_level_o (disp_level[i]),
            .alarm_o      (alarm_vec[i])
        );
    end

    assign alarm = alarm_vec;

    // Blink timebase
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             blink_q, blink_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (frame_start) begin
            if (frame_cnt_q == CNT_LAST) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
        end
    end

    // Address decode; constant divisor, so a power-of-two stride collapses to bit slicing.
    logic [31:0]        dec_off, dec_bar_full, dec_seg_full;
    logic               dec_hit;
    logic [BAR_W-1:0]   dec_bar;
    logic [LEVEL_W-1:0] dec_seg;
    logic [LEVEL_W-1:0] dec_level;
    logic               dec_alarm;

    always_comb begin
        dec_off      = 32'(pixel_addr) - BAR_BASE;
        dec_bar_full = dec_off / BAR_STRIDE;
        dec_seg_full = dec_off % BAR_STRIDE;
        dec_hit      = (32'(pixel_addr) >= BAR_BASE) && (dec_bar_full < NUM_BARS) &&
                       (dec_seg_full < SEGS);
        dec_bar      = BAR_W'(dec_bar_full);
        dec_seg      = LEVEL_W'(dec_seg_full);
        dec_level    = '0;
        dec_alarm    = 1'b0;
        if (dec_hit) begin
            dec_level = disp_level[dec_bar];
            dec_alarm = alarm_vec[dec_bar];
        end
    end

    // Stage 1: state is sampled with the pixel, so a frame_start in the same cycle is not seen.
    logic               s1_valid_q;
    logic               s1_hit_q;
    logic [BAR_W-1:0]   s1_bar_q;
    logic [LEVEL_W-1:0] s1_seg_q;
    logic [LEVEL_W-1:0] s1_level_q;
    logic               s1_alarm_q;
    logic               s1_blink_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_bar_q   <= '0;
            s1_seg_q   <= '0;
            s1_level_q <= '0;
            s1_alarm_q <= 1'b0;
            s1_blink_q <= 1'b0;
        end else begin
            s1_valid_q <= pixel_valid;
            s1_hit_q   <= dec_hit;
            s1_bar_q   <= dec_bar;
            s1_seg_q   <= dec_seg;
            s1_level_q <= dec_level;
            s1_alarm_q <= dec_alarm;
            s1_blink_q <= blink_q;
        end
    end

    // Stage 2: colour select
    logic               s2_valid_q;
    logic [COLOR_W-1:0] s2_color_q, s2_color_d;

    always_comb begin
        s2_color_d = '0;
        if (s1_valid_q && s1_hit_q && (s1_seg_q <= s1_level_q) &&
            !(s1_alarm_q && s1_blink_q)) begin
            s2_color_d = PALETTE[32'(s1_bar_q)*COLOR_W +: COLOR_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_color_q <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_color_q <= s2_color_d;
        end
    end

    assign color_valid = s2_valid_q;
    assign color_out   = s2_color_q;

endmodule

// File: tb/tb_need_bar_renderer.sv
// Directed, table-driven bench for need_bar_renderer with default parameters.
module tb_need_bar_renderer;

    localparam logic [23:0] GRN = 24'h00ff00;
    localparam logic [23:0] YEL = 24'hffff00;
    localparam logic [23:0] RED = 24'hff0000;
    localparam logic [23:0] LIM = 24'h25ff00;
    localparam logic [23:0] PUR = 24'hb70cf2;
    localparam logic [23:0] BLK = 24'h000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [14:0] levels;
    logic        pixel_valid;
    logic [6:0]  pixel_addr;
    logic        color_valid;
    logic [23:0] color_out;
    logic [4:0]  alarm;

    int checks   = 0;
    int failures = 0;

    need_bar_renderer dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .levels     (levels),
        .pixel_valid(pixel_valid),
        .pixel_addr (pixel_addr),
        .color_valid(color_valid),
        .color_out  (color_out),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [6:0]  addr;
        logic [23:0] exp;
    } pix_vec_t;

    typedef struct {
        logic        rst;
        logic        fs;
        logic        pv;
        logic [6:0]  addr;
        logic        ev;
        logic [23:0] ec;
    } cyc_vec_t;

    localparam int NV = 20;
    localparam int NS = 9;
    pix_vec_t tbl [NV];
    cyc_vec_t stm [NS];

    function automatic logic [14:0] pack_lv(input logic [2:0] l0, input logic [2:0] l1,
                                            input logic [2:0] l2, input logic [2:0] l3,
                                            input logic [2:0] l4);
        return {l4, l3, l2, l1, l0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulses(input int n);
        frame_start = 1'b1;
        repeat (n) tick();
        frame_start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic render(input string name, input logic [6:0] a, input logic [23:0] exp);
        pixel_valid = 1'b1;
        pixel_addr  = a;
        tick();
        pixel_valid = 1'b0;
        check({name, " valid@1"}, color_valid, 0);
        tick();
        check({name, " valid@2"}, color_valid, 1);
        check({name, " color"}, color_out, exp);
    endtask

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        levels = '0;
        pixel_valid = 1'b0;
        pixel_addr = '0;

        // Reset and idle
        tick();
        tick();
        check("rst color_valid", color_valid, 0);
        check("rst color_out", color_out, BLK);
        check("rst alarm", alarm, 5'b11111);
        rst = 1'b0;
        render("t1 addr64", 7'd64, GRN);

        // Ramp bar 1 toward 5 with back-to-back pulses
        levels = pack_lv(0, 5, 0, 0, 0);
        frame_start = 1'b1;
        tick();
        check("ramp alarm p1", alarm, 5'b11111);
        tick();
        check("ramp alarm p2", alarm, 5'b11101);
        tick();
        check("ramp alarm p3", alarm, 5'b11101);
        frame_start = 1'b0;
        levels = pack_lv(0, 0, 0, 0, 0);
        repeat (3) tick();
        check("levels ignored between frames", alarm, 5'b11101);

        tbl[0]  = '{1'b1, 7'd64,  GRN};
        tbl[1]  = '{1'b1, 7'd65,  BLK};
        tbl[2]  = '{1'b1, 7'd72,  YEL};
        tbl[3]  = '{1'b1, 7'd73,  YEL};
        tbl[4]  = '{1'b1, 7'd74,  YEL};
        tbl[5]  = '{1'b1, 7'd75,  YEL};
        tbl[6]  = '{1'b1, 7'd76,  BLK};
        tbl[7]  = '{1'b1, 7'd77,  BLK};
        tbl[8]  = '{1'b1, 7'd78,  BLK};
        tbl[9]  = '{1'b1, 7'd79,  BLK};
        tbl[10] = '{1'b0, 7'd72,  BLK};
        tbl[11] = '{1'b1, 7'd63,  BLK};
        tbl[12] = '{1'b1, 7'd104, BLK};
        tbl[13] = '{1'b1, 7'd127, BLK};
        tbl[14] = '{1'b1, 7'd96,  PUR};
        tbl[15] = '{1'b1, 7'd97,  BLK};
        tbl[16] = '{1'b1, 7'd88,  LIM};
        tbl[17] = '{1'b1, 7'd80,  RED};
        tbl[18] = '{1'b1, 7'd103, BLK};
        tbl[19] = '{1'b1, 7'd0,   BLK};

        // Streamed at one pixel per cycle; output of vector k-1 appears after edge k
        for (int k = 0; k <= NV; k++) begin
            if (k < NV) begin
                pixel_valid = tbl[k].pv;
                pixel_addr  = tbl[k].addr;
            end else begin
                pixel_valid = 1'b0;
            end
            tick();
            if (k >= 1) begin
                check($sformatf("tbl[%0d] addr %0d valid", k - 1, tbl[k-1].addr),
                      color_valid, tbl[k-1].pv);
                if (tbl[k-1].pv) begin
                    check($sformatf("tbl[%0d] addr %0d color", k - 1, tbl[k-1].addr),
                          color_out, tbl[k-1].exp);
                end
            end
        end
        pixel_valid = 1'b0;
        tick();

        // Pixel coinciding with frame_start sees pre-update level
        do_reset();
        levels = pack_lv(0, 3, 0, 0, 0);
        pulses(2);
        check("sim alarm", alarm, 5'b11101);
        frame_start = 1'b1;
        pixel_valid = 1'b1;
        pixel_addr  = 7'd75;
        tick();
        frame_start = 1'b0;
        tick();
        check("sim pre valid", color_valid, 1);
        check("sim pre color", color_out, BLK);
        pixel_valid = 1'b0;
        tick();
        check("sim post valid", color_valid, 1);
        check("sim post color", color_out, YEL);
        tick();

        // Blink
        do_reset();
        levels = pack_lv(0, 0, 1, 2, 0);
        pulses(15);
        check("blink alarm", alarm, 5'b10111);
        render("blink f15 addr80", 7'd80, RED);
        pulses(1);
        render("blink f16 addr80", 7'd80, BLK);
        render("blink f16 addr64", 7'd64, BLK);
        render("blink f16 addr88", 7'd88, LIM);
        render("blink f16 addr90", 7'd90, LIM);
        render("blink f16 addr91", 7'd91, BLK);
        pulses(16);
        render("blink f32 addr80", 7'd80, RED);
        render("blink f32 addr64", 7'd64, GRN);
        levels = pack_lv(0, 0, 1, 0, 0);
        pulses(1);
        check("decrement alarm", alarm, 5'b11111);
        render("decrement addr89", 7'd89, LIM);
        render("decrement addr90", 7'd90, BLK);

        // Mid-stream reset, with frame_start colliding with rst
        do_reset();
        levels = pack_lv(2, 0, 0, 0, 0);
        pulses(2);
        check("mrst pre alarm", alarm, 5'b11110);
        stm[0] = '{1'b0, 1'b0, 1'b1, 7'd64, 1'b0, BLK};
        stm[1] = '{1'b0, 1'b0, 1'b1, 7'd65, 1'b1, GRN};
        stm[2] = '{1'b1, 1'b1, 1'b1, 7'd66, 1'b0, BLK};
        stm[3] = '{1'b0, 1'b0, 1'b1, 7'd67, 1'b0, BLK};
        stm[4] = '{1'b0, 1'b0, 1'b1, 7'd68, 1'b1, BLK};
        stm[5] = '{1'b0, 1'b0, 1'b1, 7'd64, 1'b1, BLK};
        stm[6] = '{1'b0, 1'b0, 1'b1, 7'd65, 1'b1, GRN};
        stm[7] = '{1'b0, 1'b0, 1'b0, 7'd0,  1'b1, BLK};
        stm[8] = '{1'b0, 1'b0, 1'b0, 7'd0,  1'b0, BLK};
        for (int k = 0; k < NS; k++) begin
            rst         = stm[k].rst;
            frame_start = stm[k].fs;
            pixel_valid = stm[k].pv;
            pixel_addr  = stm[k].addr;
            tick();
            check($sformatf("mrst cyc%0d valid", k), color_valid, stm[k].ev);
            if (stm[k].ev) begin
                check($sformatf("mrst cyc%0d color", k), color_out, stm[k].ec);
            end
        end
        rst = 1'b0;
        frame_start = 1'b0;
        check("mrst post alarm", alarm, 5'b11111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/need_bar_renderer.md
# need_bar_renderer

Pipelined, parametrised renderer for the pet's need-status bars on the LED-matrix display path. Maps the pixel scan address to a bar segment and outputs that pixel's 24-bit colour. Each bar's displayed level animates one step per frame toward its need level. Bars at or below a low threshold blink and raise a per-bar alarm. Sits between the need-level registers and the matrix pixel multiplexer, which forwards `color_out` when `color_valid` is high.

## Interface
- `NUM_BARS`, default 5: number of need bars (channels).
- `LEVEL_W`, default 3: level width. Each bar has `SEGS = 2**LEVEL_W` segments.
- `PIX_W`, default 7: pixel address width.
- `BAR_BASE`, default 64: address of bar 0, segment 0.
- `BAR_STRIDE`, default 8: address distance between bars. Must be ≥ SEGS.
- `LOW_THRESH`, default 1: a bar is in alarm when displayed level ≤ LOW_THRESH.
- `BLINK_FRAMES`, default 16: frames per blink half-period.
- `PALETTE`, default {b70cf2, 25ff00, ff0000, ffff00, 00ff00}: 24·NUM_BARS packed colours, bar 0 in the LSBs.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `frame_start`  in  1  one-cycle pulse at the start of each display frame
- `levels`  in  NUM_BARS·LEVEL_W  packed need levels, bar 0 in the LSBs
- `pixel_valid`  in  1  a pixel address is presented this cycle
- `pixel_addr`  in  PIX_W  pixel scan address
- `color_valid`  out  1  `color_out` is valid
- `color_out`  out  24  pixel colour
- `alarm`  out  NUM_BARS  per-bar low-level flag, registered

## Operation
- **Per-bar state:** `disp_level[i]` (LEVEL_W bits).
  - On `frame_start`: if `disp_level[i] < levels[i]`, increment by 1; if greater, decrement by 1; if equal, hold.
  - Saturating, no wrap.
  - `levels` is read only on `frame_start` cycles. Changes between frames are ignored.
- **Alarm:** `alarm[i] <= (disp_level_next[i] <= LOW_THRESH)`, so it updates in the same cycle as `disp_level`.
- **Blink:**
  - `frame_cnt` counts `frame_start` pulses from 0 to BLINK_FRAMES−1.
  - On wrap to 0, `blink_phase` toggles.
- **Address decode:** `off = pixel_addr − BAR_BASE`; `bar = off / BAR_STRIDE`; `seg = off % BAR_STRIDE`.
  - Hit iff `pixel_addr ≥ BAR_BASE`, `bar < NUM_BARS` and `seg < SEGS`.
  - Constant divisor. Power-of-two stride reduces to slicing.
- **Colour rule, on a hit:**
  - Segment lit iff `seg ≤ disp_level[bar]`. Segment 0 is always lit.
  - Lit and not (`alarm[bar]` and `blink_phase`) → `PALETTE[bar]`.
  - Otherwise → 000000.
  - Non-hit addresses → 000000 with `color_valid` still asserted.

## Timing
- **Reset values:**
  - `disp_level` = 0, so `alarm` = all ones for LOW_THRESH ≥ 0.
  - `frame_cnt` = 0, `blink_phase` = 0.
  - Pipeline valids = 0, `color_out` = 0, `color_valid` = 0.
- **Pipeline:** two register stages, latency 2 cycles, throughput 1 pixel per cycle, no stall.
  - `color_valid` equals `pixel_valid` delayed by 2 cycles.
- **Stage 1** registers: hit, bar, seg, the addressed bar's `disp_level`, its `alarm`, and `blink_phase`.
  - All values are sampled at the same edge as the pixel.
  - A pixel presented in the cycle `frame_start` is high therefore uses the pre-update level and phase. No tearing within a pixel.
- **Stage 2** registers the colour and valid.
- **`rst` mid-operation:** in-flight pixels are discarded (no `color_valid`) and all state returns to reset values on the next edge. `rst` has priority over `frame_start`.
- **Back-to-back `frame_start`:** each pulse is a separate step. A level gap of N needs N pulses to close.

## Structure
- Package `need_bar_pkg` holds:
  - colour constants `C_GREEN` 00ff00, `C_YELLOW` ffff00, `C_RED` ff0000, `C_LIME` 25ff00, `C_PURPLE` b70cf2, `C_BLACK` 000000;
  - the default `PALETTE` concatenation;
  - the colour width constant (24).
- Sub-module `need_bar_channel`, generated NUM_BARS times: holds `disp_level` step logic and alarm compare.
- Top level holds `frame_cnt`, `blink_phase`, decode and the two-stage pipeline.

## Test plan
1. **Reset/idle:** `rst` high 2 cycles → `color_valid` = 0, `color_out` = 0, `alarm` = 5'b11111. Then address 64 with `pixel_valid` → `color_out` 00ff00 exactly 2 cycles later (level 0 lights segment 0).
2. **Ramp:** `levels` bar 1 = 5, pulse `frame_start` 3 times → `disp_level[1]` = 3. Addresses 72..79 render ffff00 for 72..75 and 000000 for 76..79. `alarm[1]` clears after the 2nd pulse.
3. **Decode edges:** addresses 63, 104, 127 → 000000 with `color_valid` high. Address 96 (bar 4, seg 0) → b70cf2.
4. **Blink:** bar 2 at level 1. After 16 `frame_start` pulses, address 80 → 000000. After 16 more → ff0000.
5. **Simultaneous:** pixel at 75 presented in the same cycle `frame_start` raises bar 1 from 2 to 3 → 000000. The same pixel one cycle later → ffff00.
6. **Mid-stream reset:** stream addresses 64..71 continuously, assert `rst` on the 3rd pixel → no `color_valid` for the in-flight pixels, state reset. The stream resumes with latency 2.
